// File: rtl/parser_layer_pipe_pkg.sv
// Shared parser definitions: unit width, config address map and rule entry layout.
package parser_layer_pipe_pkg;

  localparam int         UNIT_W        = 16;
  localparam logic [7:0] ENT_GLB       = 8'hFF;
  localparam logic [7:0] WORD_HIT_CNT  = 8'h10;
  localparam logic [7:0] WORD_MISS_CNT = 8'h11;

  typedef struct packed {
    logic       vld;
    logic [7:0] head_shift;
    logic [7:0] meta_shift;
  } rule_ent_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
  } key_off_t;

  function automatic logic [31:0] ent_word0(input rule_ent_t e);
    return {e.vld, 15'b0, e.head_shift, e.meta_shift};
  endfunction

  function automatic logic [31:0] key_word(input key_off_t k);
    return {16'b0, k.vld, 7'b0, k.idx};
  endfunction

endpackage

// File: rtl/parser_layer_pipe_rule_match.sv
// Combinational rule matcher: per-rule masked compare, lowest index wins.
module parser_rule_match
  import parser_layer_pipe_pkg::*;
#(
  parameter  int TYPE_NUM = 2,
  parameter  int RULE_NUM = 8,
  localparam int IDX_W    = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1
)(
  input  logic [TYPE_NUM-1:0][UNIT_W-1:0]               type_fld,
  input  logic [RULE_NUM-1:0]                           rule_vld,
  input  logic [RULE_NUM-1:0][TYPE_NUM-1:0][UNIT_W-1:0] rule_data,
  input  logic [RULE_NUM-1:0][TYPE_NUM-1:0][UNIT_W-1:0] rule_mask,
  output logic                                          hit,
  output logic [IDX_W-1:0]                              idx
);

  logic [RULE_NUM-1:0] match;

  for (genvar r = 0; r < RULE_NUM; r++) begin : g_rule
    logic [TYPE_NUM-1:0] fld_ok;
    for (genvar t = 0; t < TYPE_NUM; t++) begin : g_type
      assign fld_ok[t] = ((type_fld[t] ^ rule_data[r][t]) & rule_mask[r][t]) == '0;
    end
    assign match[r] = rule_vld[r] && (&fld_ok);
  end

  always_comb begin
    hit = |match;
    idx = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--)
      if (match[r]) idx = IDX_W'(r);
  end

endmodule

// File: rtl/parser_layer_pipe.sv
// One parser layer: type lookup against a rule table, key extraction, head/meta byte shift.
module parser_layer_pipe
  import parser_layer_pipe_pkg::*;
#(
  parameter int HEAD_W     = 512,
  parameter int META_W     = 256,
  parameter int TAG_W      = 8,
  parameter int TYPE_NUM   = 2,
  parameter int KEY_NUM    = 4,
  parameter int RULE_NUM   = 8,
  parameter int PIPE_DEPTH = 2
)(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rule_wren,
  input  logic                    i_rule_rden,
  input  logic [31:0]             i_rule_addr,
  input  logic [31:0]             i_rule_wdata,
  output logic                    o_rule_rdata_valid,
  output logic [31:0]             o_rule_rdata,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [HEAD_W+TAG_W-1:0] i_head,
  input  logic [META_W+TAG_W-1:0] i_meta,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [HEAD_W+TAG_W-1:0] o_head,
  output logic [META_W+TAG_W-1:0] o_meta,
  output logic                    o_hit
);

  localparam int UNITS  = HEAD_W / UNIT_W;
  localparam int IDX_W  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam int KEYS_W = KEY_NUM * UNIT_W;

  // Unit 0 sits at the MSB of the body; out-of-range indices read as zero.
  function automatic logic [UNIT_W-1:0] unit_at(input logic [HEAD_W-1:0] body, input logic [7:0] idx);
    logic [UNIT_W-1:0] u;
    u = '0;
    for (int i = 0; i < UNITS; i++)
      if (int'(idx) == i) u = body[HEAD_W-1-UNIT_W*i -: UNIT_W];
    return u;
  endfunction

  rule_ent_t [RULE_NUM-1:0]                           rule_q;
  logic      [RULE_NUM-1:0][TYPE_NUM-1:0][UNIT_W-1:0] tdata_q, tmask_q;
  key_off_t  [RULE_NUM-1:0][KEY_NUM-1:0]              koff_q;
  logic      [TYPE_NUM-1:0][7:0]                      toff_q;
  logic      [31:0]                                   hit_cnt, miss_cnt;

  logic [7:0] ent, word;
  logic       addr_ok, is_glb;
  assign ent     = i_rule_addr[15:8];
  assign word    = i_rule_addr[7:0];
  assign addr_ok = i_rule_addr[31:16] == '0;
  assign is_glb  = addr_ok && (ent == ENT_GLB);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_q  <= '0;
      tdata_q <= '0;
      tmask_q <= '0;
      koff_q  <= '0;
      toff_q  <= '0;
    end else if (i_rule_wren) begin
      if (is_glb) begin
        for (int t = 0; t < TYPE_NUM; t++)
          if (int'(word) == t) toff_q[t] <= i_rule_wdata[7:0];
      end else begin
        for (int r = 0; r < RULE_NUM; r++) begin
          if (addr_ok && int'(ent) == r) begin
            if (word == 8'd0) rule_q[r] <= '{vld: i_rule_wdata[31], head_shift: i_rule_wdata[15:8],
                                             meta_shift: i_rule_wdata[7:0]};
            for (int t = 0; t < TYPE_NUM; t++) begin
              if (int'(word) == 1 + t)            tdata_q[r][t] <= i_rule_wdata[UNIT_W-1:0];
              if (int'(word) == 1 + TYPE_NUM + t) tmask_q[r][t] <= i_rule_wdata[UNIT_W-1:0];
            end
            for (int k = 0; k < KEY_NUM; k++)
              if (int'(word) == 1 + 2*TYPE_NUM + k)
                koff_q[r][k] <= '{vld: i_rule_wdata[15], idx: i_rule_wdata[7:0]};
          end
        end
      end
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (is_glb) begin
      for (int t = 0; t < TYPE_NUM; t++)
        if (int'(word) == t) rd_mux = {24'b0, toff_q[t]};
      if (word == WORD_HIT_CNT)  rd_mux = hit_cnt;
      if (word == WORD_MISS_CNT) rd_mux = miss_cnt;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (addr_ok && int'(ent) == r) begin
          if (word == 8'd0) rd_mux = ent_word0(rule_q[r]);
          for (int t = 0; t < TYPE_NUM; t++) begin
            if (int'(word) == 1 + t)            rd_mux = {16'b0, tdata_q[r][t]};
            if (int'(word) == 1 + TYPE_NUM + t) rd_mux = {16'b0, tmask_q[r][t]};
          end
          for (int k = 0; k < KEY_NUM; k++)
            if (int'(word) == 1 + 2*TYPE_NUM + k) rd_mux = key_word(koff_q[r][k]);
        end
      end
    end
  end

  // Table writes land on the same edge, so the read captures the pre-write value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      o_rule_rdata_valid <= i_rule_rden;
      o_rule_rdata       <= i_rule_rden ? rd_mux : '0;
    end
  end

  logic xfer_out, clr_hit, clr_miss;
  assign xfer_out = o_valid && i_ready;
  assign clr_hit  = i_rule_wren && is_glb && (word == WORD_HIT_CNT);
  assign clr_miss = i_rule_wren && is_glb && (word == WORD_MISS_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (clr_hit)                                  hit_cnt  <= '0;
      else if (xfer_out && o_hit && hit_cnt != '1)  hit_cnt  <= hit_cnt + 32'd1;
      if (clr_miss)                                 miss_cnt <= '0;
      else if (xfer_out && !o_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  // Global stall: every stage moves together or holds together.
  logic                  advance;
  logic [PIPE_DEPTH:1]   vld_q;
  logic [PIPE_DEPTH:0]   vld_pipe;
  assign vld_pipe = {vld_q, i_valid};
  assign o_valid  = vld_pipe[PIPE_DEPTH];
  assign advance  = !o_valid || i_ready;
  assign o_ready  = advance;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[PIPE_DEPTH-1:0];
  end

  typedef struct packed {
    logic                          hit;
    logic [7:0]                    hs;
    logic [7:0]                    ms;
    key_off_t [KEY_NUM-1:0]        koff;
    logic [HEAD_W+TAG_W-1:0]       head;
    logic [META_W+TAG_W-1:0]       meta;
  } lk_t;

  logic [TYPE_NUM-1:0][UNIT_W-1:0] type_fld;
  logic [RULE_NUM-1:0]             rule_vld;
  logic                            lk_hit;
  logic [IDX_W-1:0]                lk_idx;
  lk_t                             lk_in, lk_s;

  for (genvar t = 0; t < TYPE_NUM; t++) begin : g_tfld
    assign type_fld[t] = unit_at(i_head[HEAD_W-1:0], toff_q[t]);
  end
  for (genvar r = 0; r < RULE_NUM; r++) begin : g_rvld
    assign rule_vld[r] = rule_q[r].vld;
  end

  parser_rule_match #(.TYPE_NUM(TYPE_NUM), .RULE_NUM(RULE_NUM)) u_match (
    .type_fld  (type_fld),
    .rule_vld  (rule_vld),
    .rule_data (tdata_q),
    .rule_mask (tmask_q),
    .hit       (lk_hit),
    .idx       (lk_idx)
  );

  // The selected rule's fields travel with the beat, so later table writes can't touch it.
  always_comb begin
    lk_in      = '0;
    lk_in.hit  = lk_hit;
    lk_in.head = i_head;
    lk_in.meta = i_meta;
    if (lk_hit) begin
      lk_in.hs   = rule_q[lk_idx].head_shift;
      lk_in.ms   = rule_q[lk_idx].meta_shift;
      lk_in.koff = koff_q[lk_idx];
    end
  end

  if (PIPE_DEPTH == 2) begin : g_s1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     lk_s <= '0;
      else if (advance) lk_s <= lk_in;
    end
  end else begin : g_s0
    assign lk_s = lk_in;
  end

  logic [KEYS_W-1:0] keys;
  logic [HEAD_W-1:0] head_sh;
  logic [META_W-1:0] meta_sh;

  always_comb begin
    keys = '0;
    for (int k = 0; k < KEY_NUM; k++)
      if (lk_s.koff[k].vld)
        keys[KEYS_W-UNIT_W*(k+1) +: UNIT_W] = unit_at(lk_s.head[HEAD_W-1:0], lk_s.koff[k].idx);
  end

  // Shifts of HEAD_W/8 bytes or more fall off the top and leave zero.
  assign head_sh = lk_s.head[HEAD_W-1:0] << {lk_s.hs, 3'b0};
  assign meta_sh = lk_s.meta[META_W-1:0] << {lk_s.ms, 3'b0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit  <= 1'b0;
      o_head <= '0;
      o_meta <= '0;
    end else if (advance) begin
      o_hit  <= vld_pipe[PIPE_DEPTH-1] && lk_s.hit;
      o_head <= {lk_s.head[HEAD_W +: TAG_W], head_sh};
      o_meta <= {lk_s.meta[META_W +: TAG_W], meta_sh[META_W-1:KEYS_W], keys};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_rule_wdata[30:16], meta_sh[KEYS_W-1:0]};

endmodule

// File: tb/tb_parser_layer_pipe.sv
// Directed bench for parser_layer_pipe with hand-derived expected beats.
module tb_parser_layer_pipe;

  localparam int HW = 520;
  localparam int MW = 264;

  logic          i_clk, i_rst_n;
  logic          i_rule_wren, i_rule_rden;
  logic [31:0]   i_rule_addr, i_rule_wdata;
  logic          o_rule_rdata_valid;
  logic [31:0]   o_rule_rdata;
  logic          i_valid, o_ready, o_valid, i_ready, o_hit;
  logic [HW-1:0] i_head, o_head;
  logic [MW-1:0] i_meta, o_meta;

  parser_layer_pipe dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rule_wren(i_rule_wren), .i_rule_rden(i_rule_rden),
    .i_rule_addr(i_rule_addr), .i_rule_wdata(i_rule_wdata),
    .o_rule_rdata_valid(o_rule_rdata_valid), .o_rule_rdata(o_rule_rdata),
    .i_valid(i_valid), .o_ready(o_ready), .i_head(i_head), .i_meta(i_meta),
    .o_valid(o_valid), .i_ready(i_ready), .o_head(o_head), .o_meta(o_meta), .o_hit(o_hit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic logic [511:0] put_u(input logic [511:0] b, input int idx, input logic [15:0] v);
    logic [511:0] r;
    r = b;
    r[511-16*idx -: 16] = v;
    return r;
  endfunction

  function automatic logic [HW-1:0] s_head(input int i);
    logic [511:0] b;
    b = '0;
    b = put_u(b, 0, 16'h0100 + 16'(i));
    b = put_u(b, 6, 16'h1234);
    return {8'(i + 1), b};
  endfunction

  function automatic logic [MW-1:0] s_meta(input int i);
    logic [255:0] m;
    m = 256'(i + 7) << 128;
    return {8'(i + 64), m};
  endfunction

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_rule_wren = 1'b1; i_rule_addr = a; i_rule_wdata = d;
    @(negedge i_clk);
    i_rule_wren = 1'b0;
  endtask

  task automatic cfg_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge i_clk);
    i_rule_rden = 1'b1; i_rule_addr = a;
    @(negedge i_clk);
    i_rule_rden = 1'b0;
    chk({tag, "_v"}, HW'(o_rule_rdata_valid), HW'(1'b1));
    chk(tag, HW'(o_rule_rdata), HW'(exp));
  endtask

  // Returns at the negedge where the beat sits on the output (latency 2).
  task automatic send_one(input logic [HW-1:0] h, input logic [MW-1:0] m);
    @(negedge i_clk);
    i_valid = 1'b1; i_head = h; i_meta = m; i_ready = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("lat_early", HW'(o_valid), HW'(1'b0));
    @(negedge i_clk);
  endtask

  logic [511:0] b1, b2, b3;
  logic [255:0] m1, m2, m3, msh;
  logic [HW-1:0] hit_h;
  logic [MW-1:0] hit_m;
  int sent, rcvd;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0; i_rule_wren = 1'b0; i_rule_rden = 1'b0; i_rule_addr = '0; i_rule_wdata = '0;
    i_valid = 1'b0; i_ready = 1'b1; i_head = '0; i_meta = '0;
    #3;
    chk("rst_ovalid", HW'(o_valid), '0);
    chk("rst_oready", HW'(o_ready), HW'(1'b1));
    chk("rst_ohit",   HW'(o_hit), '0);
    chk("rst_ohead",  o_head, '0);
    chk("rst_ometa",  HW'(o_meta), '0);
    chk("rst_rdv",    HW'(o_rule_rdata_valid), '0);
    chk("rst_rd",     HW'(o_rule_rdata), '0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;

    cfg_wr(32'hFF00, 32'd6);
    cfg_wr(32'h0000, 32'h8000_0E00); cfg_wr(32'h0001, 32'h0800); cfg_wr(32'h0003, 32'hFFFF);
    cfg_wr(32'h0005, 32'h8000);      cfg_wr(32'h0006, 32'h8001);
    cfg_wr(32'h0200, 32'h8000_0402); cfg_wr(32'h0201, 32'h86DD); cfg_wr(32'h0203, 32'hFFFF);
    cfg_wr(32'h0205, 32'h801F);
    cfg_wr(32'h0500, 32'h8000_0800); cfg_wr(32'h0501, 32'h86DD); cfg_wr(32'h0503, 32'hFF00);
    cfg_wr(32'h0505, 32'h8000);
    cfg_rd("rd_toff0", 32'hFF00, 32'd6);
    cfg_rd("rd_r2key0", 32'h0205, 32'h0000_801F);

    // rule0: type 0x0800 at unit 6, head shifted 14 bytes, keys from units 0 and 1
    b1 = '0;
    b1 = put_u(b1, 0, 16'h1111); b1 = put_u(b1, 1, 16'h2222);
    b1 = put_u(b1, 6, 16'h0800); b1 = put_u(b1, 31, 16'hABCD);
    m1 = {64'h0123_4567_89AB_CDEF, 64'h0F1E_2D3C_4B5A_6978, 64'h1357_9BDF_2468_ACE0, 64'hFFFF_FFFF_FFFF_FFFF};
    hit_h = {8'h5A, b1}; hit_m = {8'hC3, m1};
    send_one(hit_h, hit_m);
    chk("t1_vld",  HW'(o_valid), HW'(1'b1));
    chk("t1_hit",  HW'(o_hit), HW'(1'b1));
    chk("t1_head", o_head, {8'h5A, b1 << 112});
    chk("t1_meta", HW'(o_meta), HW'({8'hC3, m1[255:64], 64'h1111_2222_0000_0000}));

    // rules 2 and 5 both match 0x86DD; rule 2 wins (hs 4, ms 2, key0 = unit 31)
    b2 = '0;
    b2 = put_u(b2, 0, 16'h1111); b2 = put_u(b2, 6, 16'h86DD); b2 = put_u(b2, 31, 16'hABCD);
    m2 = {64'hAAAA_BBBB_CCCC_DDDD, 64'h5555_6666_7777_8888, 64'h1234_5678_9ABC_DEF0, 64'h9999_8888_7777_6666};
    msh = m2 << 16;
    send_one({8'h11, b2}, {8'h22, m2});
    chk("t2_hit",  HW'(o_hit), HW'(1'b1));
    chk("t2_head", o_head, {8'h11, b2 << 32});
    chk("t2_meta", HW'(o_meta), HW'({8'h22, msh[255:64], 64'hABCD_0000_0000_0000}));

    // miss: nothing shifted, hit low
    b3 = '0;
    b3 = put_u(b3, 0, 16'h7777); b3 = put_u(b3, 6, 16'h1234);
    m3 = {192'hFEDC_BA98_7654_3210_0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 64'h0};
    send_one({8'h33, b3}, {8'h44, m3});
    chk("t3_hit",  HW'(o_hit), '0);
    chk("t3_head", o_head, {8'h33, b3});
    chk("t3_meta", HW'(o_meta), HW'({8'h44, m3}));
    cfg_rd("cnt_hit",  32'hFF10, 32'd2);
    cfg_rd("cnt_miss", 32'hFF11, 32'd1);

    // 10-beat stream with i_ready low for 5 cycles
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
      @(negedge i_clk);
      i_ready = !(cyc >= 3 && cyc < 8);
      i_valid = (sent < 10);
      if (sent < 10) begin i_head = s_head(sent); i_meta = s_meta(sent); end
      #1;
      if (o_valid && !i_ready) chk("strm_oready", HW'(o_ready), '0);
      if (o_valid && i_ready) begin
        chk("strm_head", o_head, s_head(rcvd));
        chk("strm_meta", HW'(o_meta), HW'(s_meta(rcvd)));
        rcvd++;
      end
      if (i_valid && o_ready) sent++;
    end
    chk("strm_rcvd", HW'(rcvd), HW'(10));
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    chk("strm_nodup", HW'(o_valid), '0);

    // config port: readback, unmapped, read-during-write
    cfg_wr(32'h0100, 32'h8000_0E04);
    cfg_rd("rd_e1w0", 32'h0100, 32'h8000_0E04);
    cfg_rd("rd_unmap", 32'hFF20, 32'h0);
    @(negedge i_clk);
    i_rule_wren = 1'b1; i_rule_rden = 1'b1; i_rule_addr = 32'h0100; i_rule_wdata = 32'h8000_0102;
    @(negedge i_clk);
    i_rule_wren = 1'b0; i_rule_rden = 1'b0;
    chk("rdw_old", HW'(o_rule_rdata), HW'(32'h8000_0E04));
    cfg_rd("rdw_new", 32'h0100, 32'h8000_0102);
    cfg_wr(32'h0100, 32'h0);

    // saturation: preload near the top, then four more hits
    @(negedge i_clk);
    force dut.hit_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.hit_cnt;
    for (int i = 0; i < 4; i++) send_one(hit_h, hit_m);
    cfg_rd("cnt_sat", 32'hFF10, 32'hFFFF_FFFF);

    // clear coincident with a hit transfer: clear wins
    @(negedge i_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_head = hit_h; i_meta = hit_m;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("stall_ovalid", HW'(o_valid), HW'(1'b1));
    chk("stall_oready", HW'(o_ready), '0);
    i_ready = 1'b1; i_rule_wren = 1'b1; i_rule_addr = 32'hFF10; i_rule_wdata = 32'h1234;
    @(negedge i_clk);
    i_rule_wren = 1'b0;
    cfg_rd("cnt_clr", 32'hFF10, 32'h0);

    // reset in the middle of a 3-beat burst
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_head = s_head(i); i_meta = s_meta(i);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", HW'(o_valid), '0);
    chk("mrst_oready", HW'(o_ready), HW'(1'b1));
    chk("mrst_ohit",   HW'(o_hit), '0);
    chk("mrst_ohead",  o_head, '0);
    chk("mrst_ometa",  HW'(o_meta), '0);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1; i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("mrst_drop", HW'(o_valid), '0);
    end
    cfg_rd("mrst_r0",   32'h0000, 32'h0);
    cfg_rd("mrst_toff", 32'hFF00, 32'h0);
    cfg_rd("mrst_miss", 32'hFF11, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/parser_layer_pipe.md
PARSER_LAYER_PIPE -- requirements
Module: parser_layer_pipe

Interface
REQ-001 SHALL have parameter HEAD_W, 512, header window width in bits (multiple of 16).
REQ-002 SHALL have parameter META_W, 256, metadata width in bits.
REQ-003 SHALL have parameter TAG_W, 8, tag width carried at the MSBs of head and meta.
REQ-004 SHALL have parameter TYPE_NUM, 2, number of 16-bit type fields extracted per layer.
REQ-005 SHALL have parameter KEY_NUM, 4, number of 16-bit key fields extracted per layer.
REQ-006 SHALL have parameter RULE_NUM, 8, number of type rules.
REQ-007 SHALL have parameter PIPE_DEPTH, 2, latency in cycles; legal values are 1 and 2.
REQ-008 SHALL have port i_clk, input, 1, sole clock.
REQ-009 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-010 SHALL have ports i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata, each input, widths 1, 1, 32 and 32, forming the config write/read port.
REQ-011 SHALL have ports o_rule_rdata_valid and o_rule_rdata, each output, widths 1 and 32, carrying config read data.
REQ-012 SHALL have ports i_valid, o_ready, i_head and i_meta, with directions in, out, in, in and widths 1, 1, HEAD_W+TAG_W and META_W+TAG_W, forming the input beat.
REQ-013 SHALL have ports o_valid, i_ready, o_head, o_meta and o_hit, with directions out, in, out, out, out and widths 1, 1, HEAD_W+TAG_W, META_W+TAG_W and 1, forming the output beat.

Function
REQ-014 Config address SHALL decode as bits[15:8] = entry and bits[7:0] = word. Entry 0xFF SHALL be the global registers: word k<TYPE_NUM is type offset k; word 0x10 is the hit counter; word 0x11 is the miss counter.
REQ-015 Rule entry r<RULE_NUM SHALL use these words:
- word0: {valid[31], headShift[15:8], metaShift[7:0]} (bytes);
- word1+t: typeData t in [15:0];
- word1+TYPE_NUM+t: typeMask t;
- word1+2*TYPE_NUM+k: keyOffset k, where bit[15] = valid and [7:0] = 16-bit unit index.
REQ-016 Reads SHALL return data one cycle after i_rule_rden. Unmapped addresses SHALL return 0. A same-cycle write to the same address SHALL return the pre-write value.
REQ-017 Writes SHALL take effect the cycle after i_rule_wren. A beat in lookup SHALL use the table as sampled in its lookup cycle.
REQ-018 Type field t SHALL be the 16-bit unit at index typeOffset t, with index 0 at the MSB below the tag.
REQ-019 Lookup SHALL select the lowest-index valid rule where (type & mask) == (data & mask) for all t.
REQ-020 On a miss, all keys SHALL be 0, both shifts SHALL be 0, and o_hit SHALL be 0.
REQ-021 Key k SHALL be the 16-bit unit at keyOffset k. A key with its valid bit clear SHALL be 0.
REQ-022 o_head SHALL be i_head (below the tag) shifted toward the MSB by headShift bytes, zero-filled, with the tag unchanged. A shift of HEAD_W/8 or more SHALL give all zero.
REQ-023 o_meta SHALL be i_meta (below the tag) shifted by metaShift bytes, with the low KEY_NUM*16 bits replaced by keys {key0..keyN-1} (key0 most significant), and the tag unchanged.
REQ-024 Latency SHALL be PIPE_DEPTH cycles. With PIPE_DEPTH=2, stage 1 registers the lookup result and stage 2 registers extraction and shift.
REQ-025 Flow control SHALL be a global stall: advance = !o_valid || i_ready, and o_ready = advance. When stalled, all stage registers SHALL hold and the outputs SHALL be stable.
REQ-026 A beat SHALL transfer in when i_valid && o_ready, and out when o_valid && i_ready. Bubbles SHALL propagate as valid=0.
REQ-027 The hit and miss counters SHALL be 32-bit, increment on output transfer by o_hit, and saturate at 0xFFFFFFFF.
REQ-028 A write of any value to a counter address SHALL clear that counter. A clear SHALL take priority over a same-cycle increment.

Reset
REQ-029 While i_rst_n=0:
- o_valid, o_hit, o_rule_rdata_valid, o_rule_rdata, o_head and o_meta SHALL be 0, and o_ready SHALL be 1;
- all rule valid bits, type offsets and counters SHALL be 0.
REQ-030 Reset mid-stream SHALL drop in-flight beats with no output transfer after deassertion until new input.

Structure
REQ-031 The unit width (16), address map constants and the rule entry struct SHALL live in the shared parser package.
REQ-032 The rule match/priority encoder SHALL be sub-module parser_rule_match, which is combinational, parametrised by TYPE_NUM and RULE_NUM, and outputs the hit and the matched index.

Verification
REQ-033 Bench SHALL cover: rule0 match (type offset 6, data 0x0800, mask 0xFFFF, key offsets 0x8000/0x8001, headShift 14); input type 0x0800 -> o_hit=1, head shifted 14 bytes, keys at meta LSBs, after PIPE_DEPTH cycles.
REQ-034 Bench SHALL cover: rules 2 and 5 both matching -> rule 2 fields are used. No match -> o_hit=0, head and meta unshifted, and the miss counter becomes 1.
REQ-035 Bench SHALL cover: i_ready held low 5 cycles with a continuous 10-beat stream -> o_ready=0 while o_valid is pending, no beat lost or duplicated, and order preserved.
REQ-036 Bench SHALL cover: write entry1 word0 = 0x80000E04, then read -> rdata 0x80000E04 one cycle later; read of 0xFF20 -> 0; same-cycle write and read -> old value.
REQ-037 Bench SHALL cover: hit counter preloaded near 0xFFFFFFFF by traffic -> it holds at saturation; counter write clears it; reset asserted during a 3-beat burst -> all outputs 0 and o_ready=1.
